// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-to-one AXI4 read-channel arbiter with burst length check
//
// Shares one AXI master read port (AR/R) between two requesters, S0 and S1.
// One burst is outstanding at a time; ties go to the port that did not own
// the previous burst. Each burst's beat count is checked against its ARLEN.
//
// Ports:
//   CLK, RSTN                 clock, asynchronous active-low reset
//   S0_AR*, S1_AR*            requester address channels (ARREADY driven here)
//   S0_R*, S1_R*              requester read data channels (routed from M_R*)
//   M_AR*                     registered address channel to the bus
//   M_R*                      read data channel from the bus (M_RREADY driven here)
//   GRANT                     owner of the current burst (0 = S0, 1 = S1)
//   BUSY                      a burst is in progress
//   LEN_ERR                   sticky: RLAST seen on the wrong beat

module axi_rd_arbiter #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                    CLK,
    input  logic                    RSTN,

    input  logic [C_ADDR_WIDTH-1:0] S0_ARADDR,
    input  logic [7:0]              S0_ARLEN,
    input  logic                    S0_ARVALID,
    output logic                    S0_ARREADY,
    output logic [C_DATA_WIDTH-1:0] S0_RDATA,
    output logic [1:0]              S0_RRESP,
    output logic                    S0_RLAST,
    output logic                    S0_RVALID,
    input  logic                    S0_RREADY,

    input  logic [C_ADDR_WIDTH-1:0] S1_ARADDR,
    input  logic [7:0]              S1_ARLEN,
    input  logic                    S1_ARVALID,
    output logic                    S1_ARREADY,
    output logic [C_DATA_WIDTH-1:0] S1_RDATA,
    output logic [1:0]              S1_RRESP,
    output logic                    S1_RLAST,
    output logic                    S1_RVALID,
    input  logic                    S1_RREADY,

    output logic [C_ADDR_WIDTH-1:0] M_ARADDR,
    output logic [7:0]              M_ARLEN,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    input  logic [C_DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RLAST,
    input  logic                    M_RVALID,
    output logic                    M_RREADY,

    output logic                    GRANT,
    output logic                    BUSY,
    output logic                    LEN_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic [7:0]  beat_cnt;
    logic        req_any;
    logic        win;
    logic        rready_sel;
    logic        beat_acc;

    assign req_any = S0_ARVALID | S1_ARVALID;

    // A lone requester wins outright; on a tie the port that did not own
    // the previous burst wins.
    always_comb begin
        win = 1'b0;
        if (S0_ARVALID && !S1_ARVALID) begin
            win = 1'b0;
        end else if (S1_ARVALID && !S0_ARVALID) begin
            win = 1'b1;
        end else begin
            win = ~last_grant;
        end
    end

    assign rready_sel = GRANT ? S1_RREADY : S0_RREADY;
    assign beat_acc   = (state == ST_DATA) && M_RVALID && rready_sel;

    // Data, response and last pass straight through; only RVALID is steered,
    // so the non-granted port never sees a beat.
    assign S0_RDATA = M_RDATA;
    assign S0_RRESP = M_RRESP;
    assign S0_RLAST = M_RLAST;
    assign S1_RDATA = M_RDATA;
    assign S1_RRESP = M_RRESP;
    assign S1_RLAST = M_RLAST;

    assign BUSY = (state != ST_IDLE);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        S0_ARREADY = 1'b0;
        S1_ARREADY = 1'b0;
        S0_RVALID  = 1'b0;
        S1_RVALID  = 1'b0;
        M_RREADY   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_any) begin
                    // Held low while in reset so no handshake is ever shown
                    // to a requester during reset.
                    S0_ARREADY = RSTN & ~win;
                    S1_ARREADY = RSTN & win;
                    state_nxt  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (M_ARREADY) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                M_RREADY  = rready_sel;
                S0_RVALID = M_RVALID & ~GRANT;
                S1_RVALID = M_RVALID & GRANT;
                if (beat_acc && M_RLAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            M_ARADDR   <= '0;
            M_ARLEN    <= '0;
            M_ARVALID  <= 1'b0;
            GRANT      <= 1'b0;
            LEN_ERR    <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        M_ARADDR  <= win ? S1_ARADDR : S0_ARADDR;
                        M_ARLEN   <= win ? S1_ARLEN : S0_ARLEN;
                        GRANT     <= win;
                        M_ARVALID <= 1'b1;
                        beat_cnt  <= '0;
                    end
                end
                ST_ADDR: begin
                    if (M_ARREADY) begin
                        M_ARVALID <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (beat_acc) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        // RLAST must coincide exactly with the ARLEN-th beat;
                        // an early RLAST or a missing one both flag.
                        if (M_RLAST != (beat_cnt == M_ARLEN)) begin
                            LEN_ERR <= 1'b1;
                        end
                        if (M_RLAST) begin
                            last_grant <= GRANT;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
